hazard_control: RTL and testbench

- Owns pipeline-fill tracking and all stall, freeze and flush decisions for the 5-stage pipelined LEGv8 core.
- Produces the `stage` count consumed by the forwarding unit.
- Generates per-register write enables and flushes for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves load-use hazards, which forwarding cannot cover, data-memory wait handshakes, and taken-branch squashes.

---
 rtl/hazard_control.sv | 79 +++++++
 tb/tb_hazard_control.sv | 117 +++++++++++
 2 files changed

// File: rtl/hazard_control.sv
// hazard_control: pipeline fill tracking plus stall/freeze/flush control for the 5-stage LEGv8 core.
// Define HAZARD_STATS_EN to add stall/freeze/flush event counters.
module hazard_control #(
  parameter int COUNTERSIZE = 3,
  parameter int REGADDRSIZE = 5,
  parameter logic [REGADDRSIZE-1:0] XZR = 5'd31
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   idex_memread,
  input  logic [REGADDRSIZE-1:0] idex_rd,
  input  logic [REGADDRSIZE-1:0] ifid_ra,
  input  logic [REGADDRSIZE-1:0] ifid_rb,
  input  logic                   branch_taken,
  input  logic                   mem_req,
  input  logic                   mem_ready,
  output logic [COUNTERSIZE-1:0] stage,
  output logic                   pcwrite,
  output logic                   ifid_write,
  output logic                   idex_write,
  output logic                   exmem_write,
  output logic                   memwb_write,
  output logic                   ifid_flush,
  output logic                   idex_flush,
  output logic                   exmem_flush
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]            stall_cycles,
  output logic [31:0]            freeze_cycles,
  output logic [31:0]            flush_count
`endif
);
  typedef enum logic [1:0] {FILL = 2'd0, RUN = 2'd1, FREEZE = 2'd2} state_t;
  localparam logic [COUNTERSIZE-1:0] FULL = COUNTERSIZE'(4);
  state_t state, state_d;
  logic [COUNTERSIZE-1:0] stage_d;
  logic freeze, flush, loaduse;
  always_comb begin
    freeze = mem_req && !mem_ready;
    flush = branch_taken && !freeze;
    loaduse = !freeze && !flush && stage >= COUNTERSIZE'(2) && idex_memread && idex_rd != XZR &&
              (idex_rd == ifid_ra || idex_rd == ifid_rb);
    stage_d = freeze ? stage : flush ? '0 : stage == FULL ? FULL : stage + COUNTERSIZE'(1);
    state_d = freeze ? FREEZE :
              state == FILL ? (stage_d == FULL ? RUN : FILL) :
              state == RUN ? (flush ? FILL : RUN) :
              (!flush && stage == FULL ? RUN : FILL);
    pcwrite = !reset && !freeze && !loaduse;
    ifid_write = !reset && !freeze && !loaduse;
    idex_write = !reset && !freeze;
    exmem_write = !reset && !freeze;
    memwb_write = !reset && !freeze;
    ifid_flush = reset || flush;
    idex_flush = reset || flush || loaduse;
    exmem_flush = reset || flush;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage <= '0;
      state <= FILL;
    end else begin
      stage <= stage_d;
      state <= state_d;
    end
  end
`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
      freeze_cycles <= '0;
      flush_count <= '0;
    end else begin
      stall_cycles <= stall_cycles + {31'd0, loaduse};
      freeze_cycles <= freeze_cycles + {31'd0, freeze};
      flush_count <= flush_count + {31'd0, flush};
    end
  end
`endif
endmodule

// File: tb/tb_hazard_control.sv
// tb_hazard_control: directed scoreboard bench for hazard_control; stats checks only under HAZARD_STATS_EN.
module tb_hazard_control;
  logic clk, reset, idex_memread, branch_taken, mem_req, mem_ready;
  logic [4:0] idex_rd, ifid_ra, ifid_rb;
  logic [2:0] stage;
  logic pcwrite, ifid_write, idex_write, exmem_write, memwb_write;
  logic ifid_flush, idex_flush, exmem_flush;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles, freeze_cycles, flush_count;
`endif
  int total = 0;
  int fails = 0;
  logic [10:0] sb[$];

  hazard_control dut (
    .clk(clk), .reset(reset), .idex_memread(idex_memread), .idex_rd(idex_rd),
    .ifid_ra(ifid_ra), .ifid_rb(ifid_rb), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .stage(stage), .pcwrite(pcwrite),
    .ifid_write(ifid_write), .idex_write(idex_write), .exmem_write(exmem_write),
    .memwb_write(memwb_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush)
`ifdef HAZARD_STATS_EN
    , .stall_cycles(stall_cycles), .freeze_cycles(freeze_cycles), .flush_count(flush_count)
`endif
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // expected vector: {stage, pcwrite, ifid_w, idex_w, exmem_w, memwb_w, ifid_fl, idex_fl, exmem_fl}
  function automatic logic [10:0] nrm(input logic [2:0] s); return {s, 5'b11111, 3'b000}; endfunction
  function automatic logic [10:0] lus(input logic [2:0] s); return {s, 5'b00111, 3'b010}; endfunction
  function automatic logic [10:0] fls(input logic [2:0] s); return {s, 5'b11111, 3'b111}; endfunction
  function automatic logic [10:0] frz(input logic [2:0] s); return {s, 5'b00000, 3'b000}; endfunction
  localparam logic [10:0] RST = {3'd0, 5'b00000, 3'b111};

  task automatic cyc(input string tag, input logic rs, input logic mr, input logic [4:0] rd,
                     input logic [4:0] ra, input logic [4:0] rb, input logic bt,
                     input logic mq, input logic my, input logic [10:0] exp);
    logic [10:0] got, e;
    @(negedge clk);
    reset = rs; idex_memread = mr; idex_rd = rd; ifid_ra = ra; ifid_rb = rb;
    branch_taken = bt; mem_req = mq; mem_ready = my;
    sb.push_back(exp);
    #1;
    got = {stage, pcwrite, ifid_write, idex_write, exmem_write, memwb_write,
           ifid_flush, idex_flush, exmem_flush};
    e = sb.pop_front();
    total++;
    assert (got === e) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, got, e);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  initial begin
    reset = 1; idex_memread = 0; idex_rd = 0; ifid_ra = 0; ifid_rb = 0;
    branch_taken = 0; mem_req = 0; mem_ready = 0;
    cyc("rst0", 1, 0, 0, 0, 0, 0, 0, 0, RST);
    cyc("rst1", 1, 0, 0, 0, 0, 0, 0, 0, RST);
    cyc("fill0", 0, 0, 0, 0, 0, 0, 0, 0, nrm(0));
    cyc("fill1", 0, 0, 0, 0, 0, 0, 0, 0, nrm(1));
    cyc("fill2", 0, 0, 0, 0, 0, 0, 0, 0, nrm(2));
    cyc("fill3", 0, 0, 0, 0, 0, 0, 0, 0, nrm(3));
    cyc("fill4", 0, 0, 0, 0, 0, 0, 0, 0, nrm(4));
    cyc("sat4", 0, 0, 0, 0, 0, 0, 0, 0, nrm(4));
    chk("fsm_run", 32'(dut.state), 32'd1);
    cyc("lu_ra", 0, 1, 3, 3, 0, 0, 0, 0, lus(4));
    cyc("lu_after", 0, 0, 3, 3, 0, 0, 0, 0, nrm(4));
    cyc("lu_xzr", 0, 1, 31, 31, 31, 0, 0, 0, nrm(4));
    cyc("lu_nomatch", 0, 1, 5, 6, 7, 0, 0, 0, nrm(4));
    cyc("lu_rb", 0, 1, 7, 1, 7, 0, 0, 0, lus(4));
    cyc("br_lu", 0, 1, 3, 3, 0, 1, 0, 0, fls(4));
    cyc("refill0", 0, 0, 0, 0, 0, 0, 0, 0, nrm(0));
    cyc("lu_stage1", 0, 1, 3, 3, 0, 0, 0, 0, nrm(1));
    cyc("refill2", 0, 0, 0, 0, 0, 0, 0, 0, nrm(2));
    cyc("refill3", 0, 0, 0, 0, 0, 0, 0, 0, nrm(3));
    cyc("refill4", 0, 0, 0, 0, 0, 0, 0, 0, nrm(4));
    cyc("frz1", 0, 0, 0, 0, 0, 0, 1, 0, frz(4));
    cyc("frz2_br", 0, 0, 0, 0, 0, 1, 1, 0, frz(4));
    chk("fsm_freeze", 32'(dut.state), 32'd2);
    cyc("frz3_br", 0, 1, 3, 3, 0, 1, 1, 0, frz(4));
    cyc("frz_release_br", 0, 0, 0, 0, 0, 1, 1, 1, fls(4));
    cyc("post0", 0, 0, 0, 0, 0, 0, 0, 0, nrm(0));
    cyc("post1", 0, 0, 0, 0, 0, 0, 0, 0, nrm(1));
    cyc("post2", 0, 0, 0, 0, 0, 0, 0, 0, nrm(2));
    cyc("post3", 0, 0, 0, 0, 0, 0, 0, 0, nrm(3));
    cyc("frz_a", 0, 0, 0, 0, 0, 0, 1, 0, frz(4));
    cyc("frz_b", 0, 0, 0, 0, 0, 0, 1, 0, frz(4));
`ifdef HAZARD_STATS_EN
    chk("stall_cnt", stall_cycles, 32'd2);
    chk("flush_cnt", flush_count, 32'd2);
    chk("freeze_cnt", freeze_cycles, 32'd4);
`endif
    cyc("rst_mid_freeze", 1, 0, 0, 0, 0, 0, 1, 0, RST);
`ifdef HAZARD_STATS_EN
    chk("stall_cnt_rst", stall_cycles, 32'd0);
    chk("flush_cnt_rst", flush_count, 32'd0);
    chk("freeze_cnt_rst", freeze_cycles, 32'd0);
`endif
    cyc("rst_hold", 1, 1, 3, 3, 3, 1, 1, 0, RST);
    cyc("rel0", 0, 0, 0, 0, 0, 0, 0, 0, nrm(0));
    cyc("rel1_lu_early", 0, 1, 4, 0, 4, 0, 0, 0, nrm(1));
    cyc("rel2_lu", 0, 1, 4, 0, 4, 0, 0, 0, lus(2));
    chk("fsm_fill", 32'(dut.state), 32'd0);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
